// File: rtl/dac_ramp_if.sv
// Control/status bundle between the ramp controller and the DAC code sequencer.
// The controller drives the master side; the sequencer is the slave.
interface dac_ramp_if #(
    parameter int N      = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              tick;
    logic              clear;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      lo;
    logic [N-1:0]      hi;
    logic [N-1:0]      dacCount;
    logic              dir;
    logic              wrap;
    logic              done;
    logic              err;

    modport master (
        output en, tick, clear, mode, step, lo, hi,
        input  dacCount, dir, wrap, done, err
    );

    modport slave (
        input  en, tick, clear, mode, step, lo, hi,
        output dacCount, dir, wrap, done, err
    );
endinterface

// File: rtl/dac_ramp_gen.sv
// DAC code sequencer: steps the code between lo/hi on each tick in wrap,
// saturate, triangle or hold mode, with all status outputs registered.
module dac_ramp_gen #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic        clk,
    input  logic        nRst,
    dac_ramp_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        SAT  = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [N-1:0]  count_r, count_nxt_s;
    logic          dir_r, dir_nxt_s;
    logic          wrap_r, wrap_nxt_s;
    logic          done_r;
    logic          err_r;

    logic [N:0]    step_ext_s, cnt_ext_s, lo_ext_s, hi_ext_s;
    logic [N:0]    sum_s, lo_plus_s, diff_s;
    logic          adv_s, up_fit_s, down_fit_s, in_down_s;

    // One extra bit on every operand so hi = 2^N-1 can never roll through 0
    assign step_ext_s = {{(N + 1 - STEP_W){1'b0}}, bus.step};
    assign cnt_ext_s  = {1'b0, count_r};
    assign lo_ext_s   = {1'b0, bus.lo};
    assign hi_ext_s   = {1'b0, bus.hi};
    assign sum_s      = cnt_ext_s + step_ext_s;
    assign lo_plus_s  = lo_ext_s + step_ext_s;
    assign diff_s     = cnt_ext_s - step_ext_s;
    assign up_fit_s   = (sum_s <= hi_ext_s);
    assign down_fit_s = (cnt_ext_s >= lo_plus_s);
    assign in_down_s  = (state_r == DOWN) && (bus.mode == 2'b10);
    assign adv_s      = bus.tick && (bus.mode != 2'b11) && (step_ext_s != {(N + 1){1'b0}});

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.en) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_nxt_s = UP;
                default: begin
                    if (err_r) begin
                        state_nxt_s = state_r;
                    end else if (bus.clear) begin
                        state_nxt_s = UP;
                    end else if (adv_s && (state_r != SAT)) begin
                        if (in_down_s) begin
                            state_nxt_s = down_fit_s ? DOWN : UP;
                        end else if (up_fit_s) begin
                            state_nxt_s = UP;
                        end else begin
                            case (bus.mode)
                                2'b01:   state_nxt_s = SAT;
                                2'b10:   state_nxt_s = DOWN;
                                default: state_nxt_s = UP;
                            endcase
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
            endcase
        end
    end

    // Next code, direction and period-complete pulse
    always_comb begin
        count_nxt_s = count_r;
        dir_nxt_s   = dir_r;
        wrap_nxt_s  = 1'b0;
        if (!bus.en) begin
            count_nxt_s = count_r;
        end else begin
            case (state_r)
                IDLE: begin
                    count_nxt_s = bus.lo;
                    dir_nxt_s   = 1'b0;
                end
                default: begin
                    if (err_r) begin
                        count_nxt_s = count_r;
                    end else if (bus.clear) begin
                        count_nxt_s = bus.lo;
                        dir_nxt_s   = 1'b0;
                    end else if (adv_s && (state_r != SAT)) begin
                        if (in_down_s) begin
                            if (down_fit_s) begin
                                count_nxt_s = diff_s[N-1:0];
                            end else begin
                                count_nxt_s = bus.lo;
                                dir_nxt_s   = 1'b0;
                                wrap_nxt_s  = 1'b1;
                            end
                        end else begin
                            dir_nxt_s = 1'b0;
                            if (up_fit_s) begin
                                count_nxt_s = sum_s[N-1:0];
                            end else begin
                                case (bus.mode)
                                    2'b01: count_nxt_s = bus.hi;
                                    2'b10: begin
                                        count_nxt_s = bus.hi;
                                        dir_nxt_s   = 1'b1;
                                    end
                                    default: begin
                                        count_nxt_s = bus.lo;
                                        wrap_nxt_s  = 1'b1;
                                    end
                                endcase
                            end
                        end
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
            endcase
        end
    end

    // Registered outputs; done tracks residence in SAT
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_r <= {N{1'b0}};
            dir_r   <= 1'b0;
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            dir_r   <= dir_nxt_s;
            wrap_r  <= wrap_nxt_s;
            done_r  <= (state_nxt_s == SAT);
            err_r   <= (bus.lo > bus.hi);
        end
    end

    assign bus.dacCount = count_r;
    assign bus.dir      = dir_r;
    assign bus.wrap     = wrap_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_dac_ramp_gen.sv
// Directed bench for dac_ramp_gen: one task per scenario, hand-computed expectations.
module tb_dac_ramp_gen;
    logic clk;
    logic nRst;
    int   n_cmp;
    int   n_err;

    dac_ramp_if #(.N(8), .STEP_W(4)) bus ();

    dac_ramp_gen #(.N(8), .STEP_W(4)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.dacCount !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.dacCount); end
        n_cmp++; if (bus.dir !== 1'b0) begin n_err++; $display("FAIL reset_dir got=%b exp=0", bus.dir); end
        n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        #10 nRst = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c;
        bus.mode = 2'b00; bus.lo = 8'd0; bus.hi = 8'd255; bus.step = 4'd1; bus.en = 1'b1;
        step_clk();
        n_cmp++; if (bus.dacCount !== 8'd0) begin n_err++; $display("FAIL wrap_start got=%0d exp=0", bus.dacCount); end
        bus.tick = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step_clk();
            exp_c = i[7:0];
            n_cmp++; if (bus.dacCount !== exp_c) begin n_err++; $display("FAIL wrap_seq i=%0d got=%0d exp=%0d", i, bus.dacCount, exp_c); end
            n_cmp++; if (bus.wrap !== (i == 256)) begin n_err++; $display("FAIL wrap_pulse i=%0d got=%b exp=%b", i, bus.wrap, (i == 256)); end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_saturate();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'd17, 8'd24, 8'd31, 8'd38, 8'd45, 8'd50, 8'd50, 8'd50};
        bus.mode = 2'b01; bus.lo = 8'd10; bus.hi = 8'd50; bus.step = 4'd7; bus.clear = 1'b1;
        step_clk();
        bus.clear = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL sat_start got=%0d exp=10", bus.dacCount); end
        bus.tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_clk();
            n_cmp++; if (bus.dacCount !== exp_seq[i]) begin n_err++; $display("FAIL sat_seq i=%0d got=%0d exp=%0d", i, bus.dacCount, exp_seq[i]); end
            n_cmp++; if (bus.done !== (i >= 5)) begin n_err++; $display("FAIL sat_done i=%0d got=%b exp=%b", i, bus.done, (i >= 5)); end
        end
        bus.tick = 1'b0; bus.clear = 1'b1;
        step_clk();
        bus.clear = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL sat_clear got=%0d exp=10", bus.dacCount); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL sat_clear_done got=%b exp=0", bus.done); end
    endtask

    task automatic test_triangle();
        logic [7:0] exp_seq [9];
        logic       exp_dir [9];
        exp_seq = '{8'd6, 8'd12, 8'd18, 8'd20, 8'd14, 8'd8, 8'd2, 8'd0, 8'd6};
        exp_dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.mode = 2'b10; bus.lo = 8'd0; bus.hi = 8'd20; bus.step = 4'd6; bus.clear = 1'b1;
        step_clk();
        bus.clear = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd0) begin n_err++; $display("FAIL tri_start got=%0d exp=0", bus.dacCount); end
        bus.tick = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step_clk();
            n_cmp++; if (bus.dacCount !== exp_seq[i]) begin n_err++; $display("FAIL tri_seq i=%0d got=%0d exp=%0d", i, bus.dacCount, exp_seq[i]); end
            n_cmp++; if (bus.dir !== exp_dir[i]) begin n_err++; $display("FAIL tri_dir i=%0d got=%b exp=%b", i, bus.dir, exp_dir[i]); end
            n_cmp++; if (bus.wrap !== (i == 7)) begin n_err++; $display("FAIL tri_wrap i=%0d got=%b exp=%b", i, bus.wrap, (i == 7)); end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_no_overflow();
        bus.mode = 2'b00; bus.lo = 8'd10; bus.hi = 8'd255; bus.step = 4'd15; bus.clear = 1'b1;
        step_clk();
        bus.clear = 1'b0; bus.tick = 1'b1;
        repeat (16) step_clk();
        n_cmp++; if (bus.dacCount !== 8'd250) begin n_err++; $display("FAIL ovf_reach got=%0d exp=250", bus.dacCount); end
        step_clk();
        bus.tick = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL ovf_next got=%0d exp=10", bus.dacCount); end
        n_cmp++; if (bus.wrap !== 1'b1) begin n_err++; $display("FAIL ovf_wrap got=%b exp=1", bus.wrap); end
    endtask

    task automatic test_err();
        bus.lo = 8'd100; bus.hi = 8'd50;
        #1;
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_lag got=%b exp=0", bus.err); end
        step_clk();
        n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err_set got=%b exp=1", bus.err); end
        bus.tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL err_freeze i=%0d got=%0d exp=10", i, bus.dacCount); end
        end
        bus.tick = 1'b0; bus.clear = 1'b1;
        step_clk();
        bus.clear = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL err_clear got=%0d exp=10", bus.dacCount); end
        bus.lo = 8'd10; bus.hi = 8'd255;
        step_clk();
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_drop got=%b exp=0", bus.err); end
    endtask

    task automatic test_hold_step0();
        bus.mode = 2'b11; bus.step = 4'd1; bus.tick = 1'b1;
        repeat (3) step_clk();
        n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL hold_mode got=%0d exp=10", bus.dacCount); end
        bus.mode = 2'b00; bus.step = 4'd0;
        repeat (3) step_clk();
        n_cmp++; if (bus.dacCount !== 8'd10) begin n_err++; $display("FAIL step0_count got=%0d exp=10", bus.dacCount); end
        n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL step0_wrap got=%b exp=0", bus.wrap); end
        bus.step = 4'd1;
        step_clk();
        bus.tick = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd11) begin n_err++; $display("FAIL step1_resume got=%0d exp=11", bus.dacCount); end
    endtask

    task automatic test_enable();
        bus.en = 1'b0; bus.tick = 1'b1;
        step_clk();
        n_cmp++; if (bus.dacCount !== 8'd11) begin n_err++; $display("FAIL en_fall got=%0d exp=11", bus.dacCount); end
        step_clk();
        n_cmp++; if (bus.dacCount !== 8'd11) begin n_err++; $display("FAIL en_idle got=%0d exp=11", bus.dacCount); end
        bus.lo = 8'd3; bus.en = 1'b1;
        step_clk();
        bus.tick = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd3) begin n_err++; $display("FAIL en_rise got=%0d exp=3", bus.dacCount); end
    endtask

    task automatic test_async_reset();
        bus.mode = 2'b00; bus.lo = 8'd70; bus.hi = 8'd255; bus.step = 4'd7; bus.clear = 1'b1;
        step_clk();
        bus.clear = 1'b0; bus.tick = 1'b1;
        step_clk();
        n_cmp++; if (bus.dacCount !== 8'd77) begin n_err++; $display("FAIL arst_pre got=%0d exp=77", bus.dacCount); end
        #2 nRst = 1'b0;
        #1;
        n_cmp++; if (bus.dacCount !== 8'd0) begin n_err++; $display("FAIL arst_count got=%0d exp=0", bus.dacCount); end
        n_cmp++; if ({bus.dir, bus.wrap, bus.done, bus.err} !== 4'b0000) begin n_err++; $display("FAIL arst_flags got=%b exp=0000", {bus.dir, bus.wrap, bus.done, bus.err}); end
        bus.tick = 1'b0;
        #3 nRst = 1'b1;
        step_clk();
        n_cmp++; if (bus.dacCount !== 8'd70) begin n_err++; $display("FAIL arst_resume got=%0d exp=70", bus.dacCount); end
        bus.tick = 1'b1;
        step_clk();
        bus.tick = 1'b0;
        n_cmp++; if (bus.dacCount !== 8'd77) begin n_err++; $display("FAIL arst_step got=%0d exp=77", bus.dacCount); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        nRst = 1'b0;
        bus.en = 1'b0; bus.tick = 1'b0; bus.clear = 1'b0; bus.mode = 2'b00;
        bus.step = 4'd0; bus.lo = 8'd0; bus.hi = 8'd0;
        test_reset();
        test_wrap();
        test_saturate();
        test_triangle();
        test_no_overflow();
        test_err();
        test_hold_step0();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
